// File: rtl/instr_register_pipe_pkg.sv
// instr_register_pipe_pkg: shared widths, opcode and entry types, flag positions, overflow helper.
// Build option: INSTR_REG_SAT_EN -- when defined, overflowing results saturate instead of wrapping.
package instr_register_pipe_pkg;

    localparam int OP_W   = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;

    typedef struct packed {
        logic                   vld;
        opcode_t                opc;
        logic signed [OP_W-1:0] op_a;
        logic signed [OP_W-1:0] op_b;
        logic signed [OP_W-1:0] result;
        logic                   dz;
        logic                   ovf;
    } entry_t;

    localparam int ENTRY_W  = $bits(entry_t);
    localparam int FLAG_OVF = 0;
    localparam int FLAG_DZ  = 1;
    localparam int FLAG_VLD = ENTRY_W - 1;

`ifdef INSTR_REG_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // neg is the sign of the true (unbounded) result, selecting which rail to clamp to.
    function automatic logic [OP_W-1:0] sat_or_wrap(input logic [OP_W-1:0] low, input logic ovf, input logic neg);
        return (SAT_EN && ovf) ? (neg ? {1'b1, {(OP_W-1){1'b0}}} : {1'b0, {(OP_W-1){1'b1}}}) : low;
    endfunction

endpackage

// File: rtl/instr_register_pipe_if.sv
// instr_register_pipe_if: write/read/status bundle of the instruction register file.
// master (driver side): wr_valid, wr_ptr, opcode, operand_a, operand_b, rd_en, rd_ptr out;
//                       wr_ready, rd_valid, rd_data, busy in.  slave is the mirror image.
interface instr_register_pipe_if;
    import instr_register_pipe_pkg::*;

    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_ptr;
    opcode_t                opcode;
    logic signed [OP_W-1:0] operand_a;
    logic signed [OP_W-1:0] operand_b;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_ptr;
    logic                   rd_valid;
    entry_t                 rd_data;
    logic                   busy;

    modport master (
        output wr_valid, wr_ptr, opcode, operand_a, operand_b, rd_en, rd_ptr,
        input  wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  wr_valid, wr_ptr, opcode, operand_a, operand_b, rd_en, rd_ptr,
        output wr_ready, rd_valid, rd_data, busy
    );

endinterface

// File: rtl/instr_register_pipe_divider.sv
// instr_divider: signed restoring radix-2 divider, one quotient bit per clock, OP_W clocks per divide.
// Ports: clk, reset_n (async, active-low); i_start loads i_a / i_b (i_b must be nonzero);
//        o_done is high during the last iteration, when o_quotient / o_remainder already carry the
//        sign-corrected final values so the caller captures them on that same edge.
module instr_divider #(
    parameter int OP_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic signed [OP_W-1:0] i_a,
    input  logic signed [OP_W-1:0] i_b,
    output logic                   o_done,
    output logic signed [OP_W-1:0] o_quotient,
    output logic signed [OP_W-1:0] o_remainder
);

    localparam int CNT_W = $clog2(OP_W);

    logic             r_run;
    logic             r_qneg;
    logic             r_rneg;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_rem;
    logic [OP_W-1:0]  r_quo;
    logic [OP_W-1:0]  r_div;
    logic [OP_W:0]    w_sh;
    logic [OP_W:0]    w_diff;
    logic             w_ge;
    logic [OP_W-1:0]  w_rem_nxt;
    logic [OP_W-1:0]  w_quo_nxt;

    // r_quo starts as the dividend magnitude and shifts its bits into the partial remainder
    // while quotient bits shift in from the bottom.
    assign w_sh        = {r_rem, r_quo[OP_W-1]};
    assign w_diff      = w_sh - {1'b0, r_div};
    assign w_ge        = !w_diff[OP_W];
    assign w_rem_nxt   = w_ge ? w_diff[OP_W-1:0] : w_sh[OP_W-1:0];
    assign w_quo_nxt   = {r_quo[OP_W-2:0], w_ge};
    assign o_done      = r_run && (r_cnt == CNT_W'(OP_W-1));
    assign o_quotient  = r_qneg ? -w_quo_nxt : w_quo_nxt;
    assign o_remainder = r_rneg ? -w_rem_nxt : w_rem_nxt;

    // Magnitude of the most negative value is representable unsigned, so -MIN needs no special case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run  <= 1'b0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
        end else if (i_start) begin
            r_run  <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= i_a[OP_W-1] ? -i_a : i_a;
            r_div  <= i_b[OP_W-1] ? -i_b : i_b;
            r_qneg <= i_a[OP_W-1] ^ i_b[OP_W-1];
            r_rneg <= i_a[OP_W-1];
        end else if (r_run) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            r_run <= !o_done;
        end
    end

endmodule

// File: rtl/instr_register_pipe.sv
// instr_register_pipe: instruction register file with ALU, iterative divide and registered read port.
// Ports: clk, reset_n (async, active-low), bus (instr_register_pipe_if.slave): valid/ready write of
//        {wr_ptr, opcode, operand_a, operand_b}; rd_en/rd_ptr read returning rd_valid/rd_data one
//        cycle later; busy while a divide runs.
// Build option: INSTR_REG_SAT_EN (see instr_register_pipe_pkg) saturates overflowing results.
module instr_register_pipe
    import instr_register_pipe_pkg::*;
(
    input logic                  clk,
    input logic                  reset_n,
    instr_register_pipe_if.slave bus
);

    typedef enum logic {ST_IDLE, ST_DIV} state_t;

    localparam logic [OP_W-1:0] MIN_V = {1'b1, {(OP_W-1){1'b0}}};

    state_t                   r_state;
    state_t                   w_state_nxt;
    entry_t                   r_mem [DEPTH];
    entry_t                   r_rd_data;
    logic                     r_rd_valid;
    logic [ADDR_W-1:0]        r_ptr;
    opcode_t                  r_opc;
    logic signed [OP_W-1:0]   r_a;
    logic signed [OP_W-1:0]   r_b;
    logic                     w_acc;
    logic                     w_is_div;
    logic                     w_start;
    logic                     w_we;
    logic                     w_done;
    logic                     w_dovf;
    logic signed [OP_W-1:0]   w_quo;
    logic signed [OP_W-1:0]   w_rem;
    logic signed [OP_W:0]     w_sum;
    logic signed [OP_W:0]     w_sub;
    logic signed [2*OP_W-1:0] w_prod;
    logic [OP_W-1:0]          w_low;
    logic                     w_ovf;
    logic                     w_neg;
    entry_t                   w_alu;
    entry_t                   w_entry;
    logic [ADDR_W-1:0]        w_wptr;

    assign w_acc         = bus.wr_valid && bus.wr_ready;
    assign w_is_div      = bus.opcode inside {DIV, MOD};
    assign w_start       = w_acc && w_is_div && (bus.operand_b != '0);
    assign w_wptr        = (r_state == ST_DIV) ? r_ptr : bus.wr_ptr;
    assign bus.wr_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_DIV);
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;

    instr_divider #(.OP_W(OP_W)) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (w_start),
        .i_a         (bus.operand_a),
        .i_b         (bus.operand_b),
        .o_done      (w_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Single-cycle ALU; DIV/MOD only reach the array from here when the divisor is zero.
    always_comb begin
        w_sum  = {bus.operand_a[OP_W-1], bus.operand_a} + {bus.operand_b[OP_W-1], bus.operand_b};
        w_sub  = {bus.operand_a[OP_W-1], bus.operand_a} - {bus.operand_b[OP_W-1], bus.operand_b};
        w_prod = (2*OP_W)'(bus.operand_a) * (2*OP_W)'(bus.operand_b);
        w_low  = '0;
        w_ovf  = 1'b0;
        w_neg  = 1'b0;
        case (bus.opcode)
            PASSA: w_low = bus.operand_a;
            PASSB: w_low = bus.operand_b;
            ADD: begin
                w_low = w_sum[OP_W-1:0];
                w_ovf = w_sum[OP_W] != w_sum[OP_W-1];
                w_neg = w_sum[OP_W];
            end
            SUB: begin
                w_low = w_sub[OP_W-1:0];
                w_ovf = w_sub[OP_W] != w_sub[OP_W-1];
                w_neg = w_sub[OP_W];
            end
            MULT: begin
                w_low = w_prod[OP_W-1:0];
                w_ovf = !(&w_prod[2*OP_W-1:OP_W-1] || !(|w_prod[2*OP_W-1:OP_W-1]));
                w_neg = w_prod[2*OP_W-1];
            end
            default: ;
        endcase
        w_alu        = '0;
        w_alu.vld    = 1'b1;
        w_alu.opc    = bus.opcode;
        w_alu.op_a   = bus.operand_a;
        w_alu.op_b   = bus.operand_b;
        w_alu.result = sat_or_wrap(w_low, w_ovf, w_neg);
        w_alu.dz     = w_is_div && (bus.operand_b == '0);
        w_alu.ovf    = w_ovf;
    end

    // Only MIN / -1 overflows a divide, and its true quotient is positive.
    always_comb begin
        w_dovf  = (r_opc == DIV) && (r_a == MIN_V) && (r_b == '1);
        w_entry = w_alu;
        if (r_state == ST_DIV) begin
            w_entry.opc    = r_opc;
            w_entry.op_a   = r_a;
            w_entry.op_b   = r_b;
            w_entry.result = sat_or_wrap((r_opc == DIV) ? w_quo : w_rem, w_dovf, 1'b0);
            w_entry.dz     = 1'b0;
            w_entry.ovf    = w_dovf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_we = w_acc && !w_start;
                if (w_start) w_state_nxt = ST_DIV;
            end
            ST_DIV: begin
                w_we = w_done;
                if (w_done) w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_opc <= ZERO;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_start) begin
            r_ptr <= bus.wr_ptr;
            r_opc <= bus.opcode;
            r_a   <= bus.operand_a;
            r_b   <= bus.operand_b;
        end
    end

    // Read samples the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_we) r_mem[w_wptr] <= w_entry;
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) r_rd_data <= r_mem[bus.rd_ptr];
        end
    end

endmodule

// File: doc/instr_register_pipe.md
# instr_register_pipe

Parametrised instruction register file with a valid/ready write port, a registered read port, per-entry status flags, and a multi-cycle iterative divider. Each accepted instruction is executed on its operands and stored with its result. Single-cycle ops sustain one write per clock. DIV/MOD with a nonzero divisor stalls the write port while the divider runs. Sits between the instruction source/testbench driver and the checker/readback path of the lab DUT.

## Interface
- OP_W, 32, operand and result width (signed two's complement), ≥ 4
- DEPTH, 32, number of entries, power of two
- ADDR_W, $clog2(DEPTH), pointer width (derived)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write port can accept
- wr_ptr  in  ADDR_W  destination entry
- opcode  in  opcode_t  operation
- operand_a, operand_b  in  OP_W each  signed operands
- rd_en  in  1  read request
- rd_ptr  in  ADDR_W  source entry
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- rd_data  out  entry_t  {vld, opc, op_a, op_b, result, dz, ovf}
- busy  out  1  divider active

## Operation
- Opcodes: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD.
- Any other opcode encoding yields result 0.
- Accept = wr_valid && wr_ready.
- FSM states: IDLE, DIV. wr_ready = (state==IDLE).
- IDLE, non-divide op, or DIV/MOD with operand_b==0: entry written at the accept edge; state stays IDLE.
- IDLE, DIV/MOD with operand_b≠0: operands/pointer/opcode latched; go to DIV.
- DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, OP_W cycles. On the last cycle's edge, sign-correct, write the entry, return to IDLE.
- Signed rules: quotient truncates toward zero; the remainder takes the dividend's sign (-100 % 7 = -2).
- Divide by zero: result 0, dz=1.
- Overflow (ovf=1) when the true result does not fit OP_W signed. Cases: ADD/SUB carry-out, MULT high half not a sign-extension, DIV of MIN by -1.
  - Without the macro, the result is the low OP_W bits.
- Written entry: vld=1 plus the fields above. Out-of-range pointers cannot occur (power-of-two DEPTH).
- Read: registered, read-before-write. A same-cycle write to rd_ptr returns the old entry. rd_en=0 leaves rd_data held and rd_valid=0.
- wr_valid during DIV is ignored; the source holds the request until wr_ready.

## Timing
- Reset values: every entry all-zero (opc ZERO, vld 0), state IDLE, wr_ready 1, busy 0, rd_valid 0, rd_data 0.
- Non-divide write: written at accept edge t; a read issued at t+1 returns it at t+2.
- Divide: accept at t; wr_ready/busy low for cycles t+1..t+OP_W; entry written at edge t+OP_W; wr_ready high from t+OP_W.
- Reset during DIV: abort immediately, no entry written, all reset values restored.
- Read and write ports are independent; reads proceed while busy.

## Configuration
- INSTR_REG_SAT_EN defined: on overflow the result saturates to 2^(OP_W-1)-1 or -2^(OP_W-1), by the sign of the true result; ovf still set.
- INSTR_REG_SAT_EN undefined: on overflow the result wraps (truncated); ovf set.

## Structure
- Package instr_register_pipe_pkg contains:
  - opcode_t (4-bit enum)
  - flag bit positions
  - entry_t built from parameterised fields via a width-parameterised struct or packed typedef
  - helper function sat_or_wrap
- Sub-module instr_divider (start, a, b, done, quotient, remainder, OP_W-parametrised) holds the iterative datapath and counter. The top holds the FSM, ALU, array, and read port.

## Test plan
- Reset, then read all 32 entries → rd_data all zero, vld 0; wr_ready=1.
- ADD 7 + -3 to ptr 5, then read ptr 5 → result 4, vld 1, dz 0, ovf 0, rd_valid exactly one cycle after rd_en.
- DIV 100 / 7 to ptr 2 → wr_ready low 32 cycles, result 14. Then MOD -100 % 7 to ptr 3 → -2. Back-to-back wr_valid held → accepted on the first ready cycle.
- DIV 55 / 0 to ptr 9 → no stall, result 0, dz 1.
- ADD 0x7FFFFFFF + 1 → ovf 1; result 0x80000000 without the macro, 0x7FFFFFFF with INSTR_REG_SAT_EN. DIV 0x80000000 / -1 → ovf 1, same pattern.
- Start DIV to ptr 4, assert reset_n low at divide cycle 10 → entry 4 stays zero, busy 0, wr_ready 1 after release.
